// File: rtl/uart_time_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_time_cmd_rx
// Parses "T=HH:MM:SS\n" from a UART byte stream into BCD set-time requests.
// Rev     : 1.0
// ============================================================================
module uart_time_cmd_rx #(
  parameter int CLK_FRE    = 50,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_data_valid_i,
  output logic       rx_data_ready_o,
  output logic [7:0] set_hour_o,
  output logic [7:0] set_min_o,
  output logic [7:0] set_sec_o,
  output logic       set_valid_o,
  input  logic       set_ready_i,
  output logic       cmd_err_o
);

  localparam int                 C_TIMEOUT_CNT = CLK_FRE * 1000 * TIMEOUT_MS;
  localparam int                 C_CNT_W       = $clog2(C_TIMEOUT_CNT + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST    = C_CNT_W'(C_TIMEOUT_CNT - 1);
  localparam logic [7:0]         C_LF          = 8'h0A;
  localparam logic [7:0]         C_CR          = 8'h0D;

  typedef enum logic [3:0] {
    S_IDLE, S_EQ, S_H1, S_H0, S_C1, S_M1, S_M0, S_C2, S_S1, S_S0, S_EOL,
    S_HOLD, S_DISCARD
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         set_hour_q, set_min_q, set_sec_q;
  logic               set_valid_q, cmd_err_q, rx_ready_q;
  logic               err_d;

  logic               w_accept, w_parse, w_count, w_ok, w_digit;
  state_t             w_nxt;

  assign w_accept = rx_data_valid_i && rx_ready_q;
  assign w_digit  = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
  assign w_parse  = state_q inside {S_EQ, S_H1, S_H0, S_C1, S_M1, S_M0,
                                    S_C2, S_S1, S_S0, S_EOL};
  assign w_count  = w_parse || (state_q == S_DISCARD);

  always_comb begin
    w_ok  = 1'b0;
    w_nxt = S_IDLE;
    case (state_q)
      S_EQ:  begin w_ok = (rx_data_i == 8'h3D); w_nxt = S_H1; end
      S_H1:  begin w_ok = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h32); w_nxt = S_H0; end
      S_H0:  begin
        w_ok  = w_digit && ((hour_q[7:4] != 4'd2) || (rx_data_i <= 8'h33));
        w_nxt = S_C1;
      end
      S_C1:  begin w_ok = (rx_data_i == 8'h3A); w_nxt = S_M1; end
      S_M1:  begin w_ok = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h35); w_nxt = S_M0; end
      S_M0:  begin w_ok = w_digit; w_nxt = S_C2; end
      S_C2:  begin w_ok = (rx_data_i == 8'h3A); w_nxt = S_S1; end
      S_S1:  begin w_ok = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h35); w_nxt = S_S0; end
      S_S0:  begin w_ok = w_digit; w_nxt = S_EOL; end
      S_EOL: begin
        w_ok  = (rx_data_i == C_CR) || (rx_data_i == C_LF);
        w_nxt = (rx_data_i == C_LF) ? S_HOLD : S_EOL;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;

    if (w_accept) begin
      if (state_q == S_IDLE) begin
        if (rx_data_i == 8'h54) state_d = S_EQ;
      end else if (state_q == S_DISCARD) begin
        if (rx_data_i == C_LF) state_d = S_IDLE;
      end else if (w_parse) begin
        if (w_ok) begin
          state_d = w_nxt;
          // ASCII digits 0x30..0x39 carry their value in the low nibble
          case (state_q)
            S_H1:    hour_d[7:4] = rx_data_i[3:0];
            S_H0:    hour_d[3:0] = rx_data_i[3:0];
            S_M1:    min_d[7:4]  = rx_data_i[3:0];
            S_M0:    min_d[3:0]  = rx_data_i[3:0];
            S_S1:    sec_d[7:4]  = rx_data_i[3:0];
            S_S0:    sec_d[3:0]  = rx_data_i[3:0];
            default: ;
          endcase
        end else begin
          err_d   = 1'b1;
          state_d = (rx_data_i == C_LF) ? S_IDLE : S_DISCARD;
        end
      end
    end else if (w_count && (cnt_q >= C_CNT_LAST)) begin
      state_d = S_IDLE;
      err_d   = w_parse;
    end

    if ((state_q == S_HOLD) && set_ready_i) state_d = S_IDLE;

    if (w_accept || (state_d == S_IDLE)) cnt_d = '0;
    else if (w_count)                    cnt_d = cnt_q + C_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      cnt_q       <= '0;
      set_hour_q  <= 8'h00;
      set_min_q   <= 8'h00;
      set_sec_q   <= 8'h00;
      set_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      rx_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      cnt_q       <= cnt_d;
      cmd_err_q   <= err_d;
      set_valid_q <= (state_d == S_HOLD);
      rx_ready_q  <= (state_d != S_HOLD);
      if ((state_d == S_HOLD) && (state_q != S_HOLD)) begin
        set_hour_q <= hour_q;
        set_min_q  <= min_q;
        set_sec_q  <= sec_q;
      end
    end
  end

  assign rx_data_ready_o = rx_ready_q;
  assign set_hour_o      = set_hour_q;
  assign set_min_o       = set_min_q;
  assign set_sec_o       = set_sec_q;
  assign set_valid_o     = set_valid_q;
  assign cmd_err_o       = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_time_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_time_cmd_rx
// Directed table-driven bench for the set-time command parser.
// Rev     : 1.0
// ============================================================================
module tb_uart_time_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] set_hour, set_min, set_sec;
  logic       set_valid;
  logic       set_ready = 1'b1;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int valid_cyc = 0;
  int acc_cyc = 0;

  uart_time_cmd_rx #(.CLK_FRE(1), .TIMEOUT_MS(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data_i       (rx_data),
    .rx_data_valid_i (rx_valid),
    .rx_data_ready_o (rx_ready),
    .set_hour_o      (set_hour),
    .set_min_o       (set_min),
    .set_sec_o       (set_sec),
    .set_valid_o     (set_valid),
    .set_ready_i     (set_ready),
    .cmd_err_o       (cmd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_err)   err_cnt   <= err_cnt + 1;
    if (set_valid) valid_cyc <= valid_cyc + 1;
  end

  typedef struct {
    logic [127:0] txt;
    int           len;
    int           exp_valid;
    int           exp_err;
    logic [7:0]   h, m, s;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %0h not accepted within 100 cycles", b);
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc  = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input logic [127:0] txt, input int len);
    for (int i = 0; i < len; i++) send_byte(txt[8*(len-1-i) +: 8]);
  endtask

  task automatic clear_counts();
    repeat (4) @(negedge clk);
    err_cnt   = 0;
    valid_cyc = 0;
  endtask

  task automatic check_result(input string tag, input int ev, input int ee,
                              input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    repeat (4) @(negedge clk);
    check({tag, "_valid_cycles"}, valid_cyc, ev);
    check({tag, "_err_pulses"}, err_cnt, ee);
    check({tag, "_hour"}, set_hour, h);
    check({tag, "_min"}, set_min, m);
    check({tag, "_sec"}, set_sec, s);
  endtask

  initial begin
    int t;
    tbl[0]  = '{"T=12:34:56\n",   11, 1, 0, 8'h12, 8'h34, 8'h56};
    tbl[1]  = '{"T=24:00:00\n",   11, 0, 1, 8'h12, 8'h34, 8'h56};
    tbl[2]  = '{"T=01:02:03\n",   11, 1, 0, 8'h01, 8'h02, 8'h03};
    tbl[3]  = '{"xyT=0a:00:00\n", 13, 0, 1, 8'h01, 8'h02, 8'h03};
    tbl[4]  = '{"Q\n",             2, 0, 0, 8'h01, 8'h02, 8'h03};
    tbl[5]  = '{"T=09:59:00\n",   11, 1, 0, 8'h09, 8'h59, 8'h00};
    tbl[6]  = '{"T=12:60:00\n",   11, 0, 1, 8'h09, 8'h59, 8'h00};
    tbl[7]  = '{"T=1\n",           4, 0, 1, 8'h09, 8'h59, 8'h00};
    tbl[8]  = '{"T=20:09:45\n",   11, 1, 0, 8'h20, 8'h09, 8'h45};
    tbl[9]  = '{"T=12:34:5x\n",   11, 0, 1, 8'h20, 8'h09, 8'h45};
    tbl[10] = '{"T=12:34:56:\n",  12, 0, 1, 8'h20, 8'h09, 8'h45};

    repeat (3) @(negedge clk);
    check("rst_hour", set_hour, 8'h00);
    check("rst_valid", set_valid, 0);
    check("rst_err", cmd_err, 0);
    check("rst_ready", rx_ready, 1);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      clear_counts();
      send_str(tbl[v].txt, tbl[v].len);
      check_result($sformatf("vec%0d", v), tbl[v].exp_valid, tbl[v].exp_err,
                   tbl[v].h, tbl[v].m, tbl[v].s);
    end

    // Backpressure: set_ready low for 10 cycles, a byte waits upstream.
    clear_counts();
    set_ready = 1'b0;
    send_str("T=23:59:59\015\n", 12);
    rx_data  = 8'h54;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold_ready_%0d", i), rx_ready, 0);
      @(negedge clk);
    end
    check("hold_valid_last", set_valid, 1);
    check("hold_hour", set_hour, 8'h23);
    set_ready = 1'b1;
    @(negedge clk);
    check("post_xfer_valid", set_valid, 0);
    check("post_xfer_ready", rx_ready, 1);
    check("hold_valid_cycles", valid_cyc, 11);
    valid_cyc = 0;
    send_byte(8'h54);
    send_str("=10:20:30\n", 10);
    check_result("turnaround", 1, 0, 8'h10, 8'h20, 8'h30);

    // Inter-byte timeout inside a parse state.
    clear_counts();
    send_str("T=12:3", 6);
    t = 0;
    while (!cmd_err && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_latency", cyc - acc_cyc, 1000);
    @(negedge clk);
    check("timeout_err_width", cmd_err, 0);
    send_str("T=00:00:00\n", 11);
    check_result("after_timeout", 1, 1, 8'h00, 8'h00, 8'h00);

    // Timeout while discarding returns to IDLE silently.
    clear_counts();
    send_str("T=x", 3);
    repeat (1100) @(negedge clk);
    send_str("T=11:22:33\n", 11);
    check_result("discard_timeout", 1, 1, 8'h11, 8'h22, 8'h33);

    // Reset mid-command.
    clear_counts();
    send_str("T=1", 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_hour", set_hour, 8'h00);
    check("midrst_min", set_min, 8'h00);
    check("midrst_sec", set_sec, 8'h00);
    check("midrst_valid", set_valid, 0);
    check("midrst_err", cmd_err, 0);
    check("midrst_ready", rx_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_str("T=05:06:07\n", 11);
    check_result("after_rst", 1, 0, 8'h05, 8'h06, 8'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
